class_score_accumulator: RTL

//  Output-layer score collector that sits directly upstream of the 10-way argmax stage.
//  - Accepts a valid/ready stream of unsigned product terms, grouped by class: all terms
//    of class 0 first, then class 1, up to class NUM_CLASSES-1.
//  - Sums each class's terms with saturation and stores the sum in a per-class slot.
//  - Presents all class scores as one packed bus (Num) with out_valid/out_ready handshake.

---
 rtl/class_score_accumulator_if.sv | 25 ++
 rtl/class_score_accumulator.sv | 102 ++++++++++
 2 files changed

// File: rtl/class_score_accumulator_if.sv
// Stream-in / scores-out bus for the class score accumulator.
// The master side is the term producer together with the downstream argmax consumer.
interface class_score_accumulator_if #(
  parameter int NUM_SIZE    = 26,
  parameter int NUM_CLASSES = 10
);
  logic                            in_valid;
  logic                            in_ready;
  logic [NUM_SIZE-1:0]             in_data;
  logic                            in_last;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_SIZE*NUM_CLASSES-1:0] Num;
  logic [3:0]                      class_idx;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, Num, class_idx
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, Num, class_idx
  );
endinterface

// File: rtl/class_score_accumulator.sv
// Sums a class-ordered stream of unsigned terms with saturation into one slot per class.
// The complete score set is presented to the argmax stage with a valid/ready handshake.
module class_score_accumulator #(
  parameter int NUM_SIZE    = 26,
  parameter int NUM_CLASSES = 10
) (
  input  logic                     clk,
  input  logic                     GlobalReset,
  class_score_accumulator_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_SIZE-1:0] r_acc;
  logic [3:0]          r_class_idx;

  logic                w_in_ready;
  logic                w_out_valid;
  logic                w_beat;
  logic                w_close;
  logic                w_frame_end;
  logic [NUM_SIZE:0]   w_sum;
  logic [NUM_SIZE-1:0] w_sat;

  // The carry bit doubles as the saturation flag; a saturated acc stays saturated
  // because any further non-zero term carries out again.
  assign w_sum       = {1'b0, r_acc} + {1'b0, bus.in_data};
  assign w_sat       = w_sum[NUM_SIZE] ? {NUM_SIZE{1'b1}} : w_sum[NUM_SIZE-1:0];
  assign w_beat      = bus.in_valid & w_in_ready;
  assign w_close     = w_beat & bus.in_last;
  assign w_frame_end = w_close & (r_class_idx == LAST_IDX);

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (w_frame_end) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      r_acc       <= '0;
      r_class_idx <= '0;
    end else if (w_beat) begin
      if (bus.in_last) begin
        r_acc       <= '0;
        r_class_idx <= (r_class_idx == LAST_IDX) ? 4'd0 : r_class_idx + 4'd1;
      end else begin
        r_acc <= w_sat;
      end
    end
  end

  // Each slot register is also the Num field for its class, so Num moves only
  // when that class closes (or on reset).
  generate
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_slot
      logic [NUM_SIZE-1:0] r_slot;

      always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
          r_slot <= '0;
        end else if (w_close && (r_class_idx == 4'(gi))) begin
          r_slot <= w_sat;
        end
      end

      assign bus.Num[gi*NUM_SIZE +: NUM_SIZE] = r_slot;
    end
  endgenerate

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.class_idx = r_class_idx;

endmodule
